pipe_stage_skid: RTL

Parametrised, elastic pipeline stage register that generalises the fixed ID/EX latch into a reusable stage for any inter-stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a datapath payload and a control bundle under a valid/ready handshake, absorbs one cycle of back-pressure in a skid entry, and supports synchronous flush for branch/hazard squashing. Bubbles always present an all-zero control bundle, so downstream RegWrite and memWrite are never spuriously asserted.

---
 rtl/pipe_pkg.sv | 22 ++
 rtl/pipe_stage_stats.sv | 29 ++
 rtl/pipe_stage_skid.sv | 136 +++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline-stage definitions: the skid-stage state encoding and the
// control-bundle bit positions every stage uses to pack and unpack controls.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b10
    } stage_state_e;

    // Control-bundle bit indices (low bits of a CTRL_W-wide bundle)
    localparam int ALUSRC    = 0;
    localparam int ALUOP_LSB = 1;
    localparam int ALUOP_MSB = 2;
    localparam int REGDST    = 3;
    localparam int PCSRC     = 4;
    localparam int MEMREAD   = 5;
    localparam int MEMWRITE  = 6;
    localparam int MEMTOREG  = 7;
    localparam int REGWRITE  = 8;

endpackage

// File: rtl/pipe_stage_stats.sv
// Stage statistics: saturating counts of stalled cycles (entry presented but
// not taken) and bubble cycles (nothing presented). Cleared only by reset.
module pipe_stage_stats #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Count stall and bubble cycles, holding at all-ones instead of wrapping
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (out_valid && !out_ready) stall_cnt <= sat_inc(stall_cnt);
            if (!out_valid)              bubble_cnt <= sat_inc(bubble_cnt);
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline stage register (main entry + one skid entry) with a
// valid/ready handshake and synchronous flush. Bubbles always show an
// all-zero control bundle. Optional statistics counters are enabled with
// the PIPE_STAGE_STATS_EN macro.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
`ifdef PIPE_STAGE_STATS_EN
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
`else
    output logic [CTRL_W-1:0] out_ctrl
`endif
);

    stage_state_e      state_q, state_d;
    logic              in_ready_q;
    logic              vld_p0;
    logic              in_fire, out_fire;
    logic              load_main_in, load_main_skid, load_skid;

    logic [DATA_W-1:0] main_data_p0, skid_data_p0;
    logic [CTRL_W-1:0] main_ctrl_p0, skid_ctrl_p0;

    assign vld_p0   = (state_q != ST_EMPTY);
    assign in_fire  = in_valid && in_ready_q;
    assign out_fire = vld_p0 && out_ready;

    // Next-state and entry-load selection; flush squashes everything held
    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d      = ST_ONE;
                        load_main_in = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        load_main_in = 1'b1;
                    end else if (in_fire) begin
                        state_d   = ST_FULL;
                        load_skid = 1'b1;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        state_d        = ST_ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // State register; in_ready is its own flop so it never depends on out_ready
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != ST_FULL);
        end
    end

    // Main entry: cleared on reset so a reset stage presents zero payload
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            main_data_p0 <= '0;
            main_ctrl_p0 <= '0;
        end else if (load_main_in) begin
            main_data_p0 <= in_data;
            main_ctrl_p0 <= in_ctrl;
        end else if (load_main_skid) begin
            main_data_p0 <= skid_data_p0;
            main_ctrl_p0 <= skid_ctrl_p0;
        end
    end

    // Skid entry: only meaningful while FULL, so it needs no reset
    always_ff @(posedge clk) begin
        if (load_skid) begin
            skid_data_p0 <= in_data;
            skid_ctrl_p0 <= in_ctrl;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = vld_p0;
    assign out_data  = main_data_p0;
    assign out_ctrl  = vld_p0 ? main_ctrl_p0 : '0;

`ifdef PIPE_STAGE_STATS_EN
    pipe_stage_stats #(
        .CNT_W (CNT_W)
    ) u_stats (
        .clk        (clk),
        .reset_n    (reset_n),
        .out_valid  (vld_p0),
        .out_ready  (out_ready),
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
    );
`else
    // Statistics disabled: counter width has no hardware to size
    if (CNT_W > 0) begin : g_stats_off
    end
`endif

endmodule
